// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shift controller for the execute path.
// Implements SLL, SRL, SRA and LUI with one working register, a fixed
// shift-by-16 step and a shift-by-1 step instead of a barrel shifter.
//
// Ports:
//   clk    - system clock, rising-edge active
//   rst_n  - asynchronous active-low reset
//   start  - request; sampled only while idle
//   op     - 00 SLL, 01 SRL, 10 SRA, 11 LUI
//   in     - operand, sampled with start
//   shamt  - shift amount, sampled with start (ignored for LUI)
//   out    - result register, updated only on entry to the done cycle
//   busy   - high whenever not idle
//   done   - one-cycle pulse, out valid from this cycle onward
module shift_sequencer #(
   parameter int unsigned size = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [size-1:0] in,
   input  logic [4:0]      shamt,
   output logic [size-1:0] out,
   output logic            busy,
   output logic            done
);

   localparam logic [1:0] OpSll = 2'b00;
   localparam logic [1:0] OpSrl = 2'b01;
   localparam logic [1:0] OpSra = 2'b10;
   localparam logic [1:0] OpLui = 2'b11;

   typedef enum logic [1:0] {StIdle, StShift16, StShift1, StDone} state_e;

   state_e          state_q;
   logic [size-1:0] work_q;
   logic [3:0]      count_q;
   logic [1:0]      op_q;
   logic            big_q;

   logic            is_lui;
   logic            eff_big;
   logic [3:0]      eff_count;
   logic            left;
   logic            fill;
   logic [size-1:0] work_sh16;
   logic [size-1:0] work_sh1;
   logic [size-1:0] work_step;

   // LUI reuses the shift-by-16 step as a left shift with no single-bit steps.
   always_comb begin
      is_lui    = (op == OpLui);
      eff_big   = is_lui | shamt[4];
      eff_count = is_lui ? 4'd0 : shamt[3:0];
   end

   always_comb begin
      left      = (op_q == OpSll) || (op_q == OpLui);
      fill      = (op_q == OpSra) & work_q[size-1];
      work_sh16 = left ? {work_q[size-17:0], 16'h0000} : {{16{fill}}, work_q[size-1:16]};
      work_sh1  = left ? {work_q[size-2:0], 1'b0} : {fill, work_q[size-1:1]};
      // big_q is consumed by the shift-by-16 step, so later steps are single-bit.
      work_step = big_q ? work_sh16 : work_sh1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         work_q  <= '0;
         count_q <= '0;
         op_q    <= '0;
         big_q   <= 1'b0;
         out     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  work_q  <= in;
                  op_q    <= op;
                  big_q   <= eff_big;
                  count_q <= eff_count;
                  busy    <= 1'b1;
                  if (eff_big) begin
                     state_q <= StShift16;
                  end else if (eff_count != 4'd0) begin
                     state_q <= StShift1;
                  end else begin
                     // Zero shift: the operand is the result.
                     state_q <= StDone;
                     out     <= in;
                     done    <= 1'b1;
                  end
               end
            end
            StShift16: begin
               work_q <= work_step;
               big_q  <= 1'b0;
               if (count_q != 4'd0) begin
                  state_q <= StShift1;
               end else begin
                  state_q <= StDone;
                  out     <= work_step;
                  done    <= 1'b1;
               end
            end
            StShift1: begin
               work_q  <= work_step;
               count_q <= count_q - 4'd1;
               if (count_q == 4'd1) begin
                  state_q <= StDone;
                  out     <= work_step;
                  done    <= 1'b1;
               end
            end
            StDone: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: self-checking bench for shift_sequencer (size = 32).
// Expected results and latencies come from a behavioural model using plain
// shift operators; random and directed operations are run through one task.
module tb_shift_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] in;
   logic [4:0]  shamt;
   logic [31:0] out;
   logic        busy;
   logic        done;

   int          n_checks;
   int          n_pass;
   logic [31:0] last_out;

   shift_sequencer #(.size(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .in    (in),
      .shamt (shamt),
      .out   (out),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                              input logic [4:0] s);
      logic [31:0] r;
      case (o)
         2'b00:   r = a << s;
         2'b01:   r = a >> s;
         2'b10:   r = $unsigned($signed(a) >>> s);
         default: r = a << 16;
      endcase
      return r;
   endfunction

   // Edges from (and including) the accepting edge until done is visible.
   function automatic int ref_edges(input logic [1:0] o, input logic [4:0] s);
      if (o == 2'b11) return 2;
      return int'(s[4]) + int'(s[3:0]) + 1;
   endfunction

   task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [4:0] s);
      logic [31:0] exp;
      int          n_exp;
      int          lat;
      exp   = ref_result(o, a, s);
      n_exp = ref_edges(o, s);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      in    = a;
      shamt = s;
      @(posedge clk);
      #1;
      // Scramble inputs after acceptance; the operation must not see them.
      start = 1'b0;
      op    = 2'($urandom);
      in    = $urandom;
      shamt = 5'($urandom);
      lat   = 1;
      while (done !== 1'b1 && lat < 20) begin
         check_eq("busy_run", 32'(busy), 32'd1);
         check_eq("out_hold_run", out, last_out);
         @(posedge clk);
         #1;
         lat++;
      end
      check_eq("latency", lat, n_exp);
      check_eq("busy_done", 32'(busy), 32'd1);
      check_eq("result", out, exp);
      last_out = exp;
      @(posedge clk);
      #1;
      check_eq("done_pulse", 32'(done), 32'd0);
      check_eq("idle_busy", 32'(busy), 32'd0);
      check_eq("out_hold_idle", out, exp);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      last_out = 32'h0;
      rst_n    = 1'b0;
      start    = 1'b0;
      op       = 2'b00;
      in       = 32'h0;
      shamt    = 5'd0;
      #3;
      check_eq("reset_out", out, 32'h0);
      check_eq("reset_busy", 32'(busy), 32'd0);
      check_eq("reset_done", 32'(done), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed cases.
      do_op(2'b11, 32'h0000_ABCD, 5'd7);
      do_op(2'b00, 32'h0000_0001, 5'd0);
      do_op(2'b00, 32'h0000_0001, 5'd31);
      do_op(2'b10, 32'h8000_0000, 5'd20);
      do_op(2'b01, 32'h8000_0000, 5'd20);

      // Start held high: accept, 4 single steps, done, one idle cycle, repeat.
      @(negedge clk);
      start = 1'b1;
      op    = 2'b01;
      in    = 32'hF000_0000;
      shamt = 5'd4;
      for (int i = 1; i <= 18; i++) begin
         @(posedge clk);
         #1;
         check_eq("b2b_done", 32'(done), 32'((i % 6) == 5));
         check_eq("b2b_busy", 32'(busy), 32'((i % 6) != 0));
         if ((i % 6) == 5) check_eq("b2b_out", out, 32'h0F00_0000);
      end
      start    = 1'b0;
      last_out = 32'h0F00_0000;

      // Inputs change during the single-bit steps inside do_op; then hold.
      do_op(2'b00, 32'h0000_0003, 5'd3);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check_eq("idle_hold", out, 32'h0000_0018);
      end

      // Asynchronous reset in the middle of single-bit steps.
      @(negedge clk);
      start = 1'b1;
      op    = 2'b00;
      in    = $urandom | 32'h1;
      shamt = 5'd12;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      check_eq("pre_reset_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("async_out", out, 32'h0);
      check_eq("async_busy", 32'(busy), 32'd0);
      check_eq("async_done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n    = 1'b1;
      last_out = 32'h0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         check_eq("no_done_after_reset", 32'(done), 32'd0);
      end
      do_op(2'b00, 32'h0000_0001, 5'd1);

      // Random operations.
      for (int i = 0; i < 40; i++) begin
         do_op(2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
